// File: rtl/cdma_walsh_link.sv
// Walsh-code CDMA link: spreads NUM_PORTS words bit-serially onto one summed channel and despreads them.
// Decoded frame appears DATA_WIDTH*NUM_PORTS+1 cycles after acceptance; one-deep shadow buffer, no output backpressure.
module cdma_walsh_link #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_mask,
  input  logic                            err_inj,
  output logic [$clog2(NUM_PORTS)+1:0]    chip_sum,
  output logic                            busy,
  output logic                            out_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_mask,
  output logic                            out_err
);
  localparam int CW = $clog2(NUM_PORTS);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SW = CW + 2;
  localparam int AW = 2*CW + 3;
  localparam int FW = NUM_PORTS*DATA_WIDTH;
  localparam logic [CW-1:0] CHIP_LAST = CW'(NUM_PORTS-1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(DATA_WIDTH-1);
  localparam logic [AW-1:0] CL_POS    = AW'(NUM_PORTS);
  localparam logic [AW-1:0] CL_NEG    = AW'(-NUM_PORTS);

  typedef enum logic {IDLE, SEND} state_t;

  // Walsh chip is -1 when parity(p & c) is odd
  function automatic logic w_neg(input int p, input logic [CW-1:0] c);
    logic [CW-1:0] pv;
    pv = CW'(p);
    return ^(pv & c);
  endfunction

  state_t          state_q, state_d;
  logic [FW-1:0]   work_dat_q, work_dat_d;
  logic [NUM_PORTS-1:0] work_mask_q, work_mask_d;
  logic            sh_vld_q, sh_vld_d;
  logic [FW-1:0]   sh_dat_q, sh_dat_d;
  logic [NUM_PORTS-1:0] sh_mask_q, sh_mask_d;
  logic [CW-1:0]   chip_q, chip_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [SW-1:0]   chip_sum_q, chip_sum_d;
  logic            accept, sending, last_chip;

  assign in_ready  = !sh_vld_q;
  assign accept    = in_valid && in_ready;
  assign sending   = (state_q == SEND);
  assign last_chip = sending && (chip_q == CHIP_LAST) && (bit_q == '0);

  always_comb begin
    state_d     = state_q;
    work_dat_d  = work_dat_q;
    work_mask_d = work_mask_q;
    sh_vld_d    = sh_vld_q;
    sh_dat_d    = sh_dat_q;
    sh_mask_d   = sh_mask_q;
    chip_d      = chip_q;
    bit_d       = bit_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_dat_d  = in_data;
          work_mask_d = in_mask;
          chip_d      = '0;
          bit_d       = BIT_FIRST;
          state_d     = SEND;
        end
      end
      SEND: begin
        chip_d = chip_q + 1'b1;
        if (chip_q == CHIP_LAST) bit_d = bit_q - BW'(1);
        if (last_chip) begin
          chip_d = '0;
          bit_d  = BIT_FIRST;
          if (sh_vld_q) begin
            work_dat_d  = sh_dat_q;
            work_mask_d = sh_mask_q;
            sh_vld_d    = 1'b0;
          end else if (accept) begin
            // shadow is empty, so a same-cycle offer goes straight to the working register
            work_dat_d  = in_data;
            work_mask_d = in_mask;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          sh_vld_d  = 1'b1;
          sh_dat_d  = in_data;
          sh_mask_d = in_mask;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chip_sum_d = '0;
    if (sending) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (work_mask_q[p]) begin
          if (work_dat_q[p*DATA_WIDTH + int'(bit_q)] ^ w_neg(p, chip_q)) chip_sum_d = chip_sum_d + SW'(1);
          else chip_sum_d = chip_sum_d - SW'(1);
        end
      end
      if (err_inj) chip_sum_d = chip_sum_d + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      work_dat_q  <= '0;
      work_mask_q <= '0;
      sh_vld_q    <= 1'b0;
      sh_dat_q    <= '0;
      sh_mask_q   <= '0;
      chip_q      <= '0;
      bit_q       <= '0;
      chip_sum_q  <= '0;
    end else begin
      state_q     <= state_d;
      work_dat_q  <= work_dat_d;
      work_mask_q <= work_mask_d;
      sh_vld_q    <= sh_vld_d;
      sh_dat_q    <= sh_dat_d;
      sh_mask_q   <= sh_mask_d;
      chip_q      <= chip_d;
      bit_q       <= bit_d;
      chip_sum_q  <= chip_sum_d;
    end
  end

  // Decoder runs one cycle behind the encoder, aligned to the registered channel value
  logic                 dvld_q, dfirst_q, dlast_q;
  logic [CW-1:0]        dchip_q;
  logic [NUM_PORTS-1:0] dmask_q;
  logic [AW-1:0]        acc_q [NUM_PORTS];
  logic [AW-1:0]        acc_d [NUM_PORTS];
  logic [AW-1:0]        cs_ext;
  logic [NUM_PORTS-1:0] bit_dec;
  logic [FW-1:0]        word_q, word_d;
  logic                 ferr_q, ferr_d, bit_err;
  logic                 out_valid_q, out_err_q;
  logic [FW-1:0]        out_data_q;
  logic [NUM_PORTS-1:0] out_mask_q;

  always_comb begin
    cs_ext  = {{(AW-SW){chip_sum_q[SW-1]}}, chip_sum_q};
    bit_err = 1'b0;
    bit_dec = '0;
    word_d  = word_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      acc_d[p] = (dchip_q == '0) ? '0 : acc_q[p];
      acc_d[p] = w_neg(p, dchip_q) ? (acc_d[p] - cs_ext) : (acc_d[p] + cs_ext);
      bit_dec[p] = dmask_q[p] && !acc_d[p][AW-1] && (acc_d[p] != '0);
      word_d[p*DATA_WIDTH +: DATA_WIDTH] =
        (word_q[p*DATA_WIDTH +: DATA_WIDTH] << 1) | DATA_WIDTH'(bit_dec[p]);
      if (dmask_q[p] ? ((acc_d[p] != CL_POS) && (acc_d[p] != CL_NEG)) : (acc_d[p] != '0))
        bit_err = 1'b1;
    end
    ferr_d = (dfirst_q ? 1'b0 : ferr_q) | (bit_err && (dchip_q == CHIP_LAST));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvld_q      <= 1'b0;
      dfirst_q    <= 1'b0;
      dlast_q     <= 1'b0;
      dchip_q     <= '0;
      dmask_q     <= '0;
      for (int p = 0; p < NUM_PORTS; p++) acc_q[p] <= '0;
      word_q      <= '0;
      ferr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      dvld_q      <= sending;
      dfirst_q    <= sending && (chip_q == '0) && (bit_q == BIT_FIRST);
      dlast_q     <= last_chip;
      dchip_q     <= chip_q;
      dmask_q     <= work_mask_q;
      out_valid_q <= dvld_q && dlast_q;
      if (dvld_q) begin
        for (int p = 0; p < NUM_PORTS; p++) acc_q[p] <= acc_d[p];
        ferr_q <= ferr_d;
        if (dchip_q == CHIP_LAST) word_q <= word_d;
        if (dlast_q) begin
          out_data_q <= word_d;
          out_mask_q <= dmask_q;
          out_err_q  <= ferr_d;
        end
      end
    end
  end

  assign chip_sum  = chip_sum_q;
  assign busy      = sending || dvld_q || out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_cdma_walsh_link.sv
// Bench for cdma_walsh_link: table vectors, back-to-back and reset sequences, random frames vs. a Walsh arithmetic model.
module tb_cdma_walsh_link;
  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int CL    = NP;
  localparam int FRAME = DW*CL;
  localparam int FW    = NP*DW;
  localparam int SW    = $clog2(NP)+2;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, err_inj, busy, out_valid, out_err;
  logic [FW-1:0] in_data, out_data;
  logic [NP-1:0] in_mask, out_mask;
  logic [SW-1:0] chip_sum;

  int checks = 0;
  int errors = 0;

  cdma_walsh_link #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .err_inj(err_inj),
    .chip_sum(chip_sum), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_mask(out_mask), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: direct spreading sum and correlation, frame at a time
  int            m_chips [FRAME];
  logic [FW-1:0] m_data;
  logic          m_err;

  function automatic int walsh(int p, int c);
    return ($countones(p & c) % 2 == 0) ? 1 : -1;
  endfunction

  task automatic model(input logic [FW-1:0] d, input logic [NP-1:0] m, input int errchip);
    for (int k = 0; k < FRAME; k++) begin
      int b, c, s;
      b = DW-1 - k/CL;
      c = k % CL;
      s = 0;
      for (int p = 0; p < NP; p++)
        if (m[p]) s += (d[p*DW+b] ? 1 : -1) * walsh(p, c);
      if (k == errchip) s += 1;
      m_chips[k] = s;
    end
    m_data = '0;
    m_err  = 1'b0;
    for (int i = 0; i < DW; i++) begin
      for (int p = 0; p < NP; p++) begin
        int acc;
        acc = 0;
        for (int c = 0; c < CL; c++) acc += walsh(p, c) * m_chips[i*CL+c];
        if (m[p] && acc > 0) m_data[p*DW + DW-1-i] = 1'b1;
        if (m[p] ? (acc != CL && acc != -CL) : (acc != 0)) m_err = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [FW-1:0] d, input logic [NP-1:0] m,
                           input int errchip, input logic [FW-1:0] ed, input logic [NP-1:0] em,
                           input logic ee);
    model(d, m, errchip);
    in_data  = d;
    in_mask  = m;
    in_valid = 1'b1;
    check({name, "/in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = FW'($urandom);
    in_mask  = NP'($urandom);
    for (int n = 0; n <= FRAME+2; n++) begin
      if (n > 0) begin
        if (n <= FRAME) check({name, "/chip_sum"}, int'($signed(chip_sum)), m_chips[n-1]);
        else            check({name, "/chip_sum_idle"}, int'($signed(chip_sum)), 0);
        check({name, "/out_valid"}, out_valid, n == FRAME+1);
        check({name, "/busy"}, busy, n <= FRAME+1);
        if (n >= FRAME+1) begin
          check({name, "/out_data"}, out_data, ed);
          check({name, "/out_mask"}, out_mask, em);
          check({name, "/out_err"}, out_err, ee);
        end
      end
      err_inj = (n == errchip);
      tick();
    end
    err_inj = 1'b0;
  endtask

  task automatic run_b2b();
    int            a_ch [FRAME];
    int            b_ch [FRAME];
    int            c_ch [FRAME];
    logic [FW-1:0] a_d, b_d, c_d, c_in;
    logic [NP-1:0] c_m;
    logic          a_e, b_e, c_e;
    int            exp_cs;
    c_in = FW'($urandom);
    c_m  = NP'($urandom_range(1, (1 << NP) - 1));
    model(32'h00FF3CA5, 4'b1111, -1); a_ch = m_chips; a_d = m_data; a_e = m_err;
    model(32'hAA558001, 4'b1111, -1); b_ch = m_chips; b_d = m_data; b_e = m_err;
    model(c_in, c_m, -1);             c_ch = m_chips; c_d = m_data; c_e = m_err;
    in_data  = 32'h00FF3CA5;
    in_mask  = 4'b1111;
    in_valid = 1'b1;
    check("b2b/in_ready0", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int n = 0; n <= 3*FRAME+4; n++) begin
      if (n > 0) begin
        exp_cs = 0;
        if (n <= FRAME)        exp_cs = a_ch[n-1];
        else if (n <= 2*FRAME) exp_cs = b_ch[n-FRAME-1];
        else if (n <= 3*FRAME) exp_cs = c_ch[n-2*FRAME-1];
        check("b2b/chip_sum", int'($signed(chip_sum)), exp_cs);
        check("b2b/in_ready", in_ready,
              !((n >= 5 && n <= FRAME-1) || (n >= FRAME+1 && n <= 2*FRAME-1)));
        check("b2b/out_valid", out_valid, n == FRAME+1 || n == 2*FRAME+1 || n == 3*FRAME+1);
        check("b2b/busy", busy, n <= 3*FRAME+1);
        if (n == FRAME+1) begin
          check("b2b/A_data", out_data, a_d);
          check("b2b/A_err", out_err, a_e);
        end
        if (n == 2*FRAME+1) begin
          check("b2b/B_data", out_data, b_d);
          check("b2b/B_err", out_err, b_e);
        end
        if (n == 3*FRAME+1) begin
          check("b2b/C_data", out_data, c_d);
          check("b2b/C_mask", out_mask, c_m);
          check("b2b/C_err", out_err, c_e);
        end
      end
      if (n == 4) begin
        in_valid = 1'b1;
        in_data  = 32'hAA558001;
        in_mask  = 4'b1111;
      end else if (n == 5) begin
        in_data = c_in;
        in_mask = c_m;
      end else if (n == FRAME+1) begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [FW-1:0] d;
    logic [NP-1:0] m;
    int            errchip;
    logic [FW-1:0] ed;
    logic [NP-1:0] em;
    logic          ee;
  } vec_t;

  vec_t vecs [7];

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mask  = '0;
    err_inj  = 1'b0;
    #12;
    check("rst/busy", busy, 1'b0);
    check("rst/out_valid", out_valid, 1'b0);
    check("rst/out_data", out_data, '0);
    check("rst/out_mask", out_mask, '0);
    check("rst/out_err", out_err, 1'b0);
    check("rst/chip_sum", chip_sum, '0);
    rst = 1'b1;
    tick();
    check("rst/in_ready", in_ready, 1'b1);

    vecs[0] = '{32'h00FF3CA5, 4'b1111, -1, 32'h00FF3CA5, 4'b1111, 1'b0};
    vecs[1] = '{32'h44332211, 4'b0101, -1, 32'h00330011, 4'b0101, 1'b0};
    vecs[2] = '{32'h00FF3CA5, 4'b1111,  3, 32'h00FF3CA5, 4'b1111, 1'b1};
    vecs[3] = '{32'h00FF3CA5, 4'b1111, -1, 32'h00FF3CA5, 4'b1111, 1'b0};
    vecs[4] = '{32'hDEADBEEF, 4'b0000, -1, 32'h00000000, 4'b0000, 1'b0};
    vecs[5] = '{32'h00005A00, 4'b0010, 10, 32'h00005A00, 4'b0010, 1'b1};
    vecs[6] = '{32'h7E000000, 4'b1000, 31, 32'h7E000000, 4'b1000, 1'b1};
    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].m, vecs[i].errchip,
                vecs[i].ed, vecs[i].em, vecs[i].ee);

    run_b2b();

    for (int i = 0; i < 24; i++) begin
      logic [FW-1:0] d;
      logic [NP-1:0] m;
      int            e;
      d = FW'($urandom);
      m = NP'($urandom_range(0, (1 << NP) - 1));
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME-1)) : -1;
      model(d, m, e);
      run_frame($sformatf("rnd%0d", i), d, m, e, m_data, m, m_err);
    end

    // Reset in the middle of a frame, with the previous decode still held on the outputs
    run_frame("pre_rst", vecs[0].d, vecs[0].m, -1, vecs[0].ed, vecs[0].em, 1'b0);
    in_data  = vecs[0].d;
    in_mask  = vecs[0].m;
    in_valid = 1'b1;
    check("midrst/in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("midrst/busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst/busy", busy, 1'b0);
    check("midrst/out_valid", out_valid, 1'b0);
    check("midrst/out_data", out_data, '0);
    check("midrst/out_mask", out_mask, '0);
    check("midrst/out_err", out_err, 1'b0);
    check("midrst/chip_sum", chip_sum, '0);
    tick();
    tick();
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      check("midrst/no_out_valid", out_valid, 1'b0);
      check("midrst/idle_busy", busy, 1'b0);
    end
    run_frame("post_rst", vecs[0].d, vecs[0].m, -1, vecs[0].ed, vecs[0].em, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
